// File: rtl/matrix_tile_reader_pkg.sv
// Shared types and sizes for the 4x4 signed tile reader.
// MATRIX_TILE_READER_OOB_CHECK_EN adds the out-of-range address flag.
package matrix_tile_reader_pkg;

    localparam int unsigned TILE_DIM  = 4;
    localparam int unsigned ELEM_W    = 8;
    localparam int unsigned NUM_ELEMS = TILE_DIM * TILE_DIM;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned DIM_W     = 16;
    // Wide enough that (row+3)*cols + col + 3 + base never overflows.
    localparam int unsigned FULL_W    = 34;

    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef elem_t [0:TILE_DIM-1][0:TILE_DIM-1] tile_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [DIM_W-1:0] cols;
        logic [DIM_W-1:0] row;
        logic [DIM_W-1:0] col;
    } tile_req_t;

endpackage

// File: rtl/matrix_tile_reader_if.sv
// Controller/memory-side bundle of the tile reader; slave = reader, master = its environment.
// MATRIX_TILE_READER_OOB_CHECK_EN adds oob_o.
interface matrix_tile_reader_if #(
    parameter int unsigned AddrWidth = 8
);
    import matrix_tile_reader_pkg::*;

    logic                 start_i;
    logic [AddrWidth-1:0] base_addr_i;
    logic [DIM_W-1:0]     matrix_cols_i;
    logic [DIM_W-1:0]     start_row_i;
    logic [DIM_W-1:0]     start_col_i;
    logic                 busy_o;
    logic                 done_o;
    logic [AddrWidth-1:0] mem_addr_o;
    elem_t                mem_rd_data_i;
    tile_t                matrix_o;
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
    logic                 oob_o;
`endif

    modport slave (
        input  start_i, base_addr_i, matrix_cols_i, start_row_i, start_col_i, mem_rd_data_i,
        output busy_o, done_o, mem_addr_o, matrix_o
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
        , output oob_o
`endif
    );

    modport master (
        output start_i, base_addr_i, matrix_cols_i, start_row_i, start_col_i, mem_rd_data_i,
        input  busy_o, done_o, mem_addr_o, matrix_o
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
        , input oob_o
`endif
    );

endinterface

// File: rtl/matrix_tile_reader_addr_gen.sv
// Combinational element address for tile index k; wraps modulo 2**AddrWidth.
// MATRIX_TILE_READER_OOB_CHECK_EN adds the untruncated-overflow flag.
module tile_addr_gen
    import matrix_tile_reader_pkg::*;
#(
    parameter int unsigned AddrWidth = 8
) (
    input  logic [AddrWidth-1:0] base_i,
    input  tile_req_t            req_i,
    input  logic [IDX_W-1:0]     idx_i,
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
    output logic                 oob_c_o,
`endif
    output logic [AddrWidth-1:0] addr_c_o
);

    logic [FULL_W-1:0] full_addr;

    always_comb begin
        full_addr = FULL_W'(base_i)
                  + (FULL_W'(req_i.row) + FULL_W'(idx_i[IDX_W-1:2])) * FULL_W'(req_i.cols)
                  + FULL_W'(req_i.col) + FULL_W'(idx_i[1:0]);
    end

    assign addr_c_o = full_addr[AddrWidth-1:0];

`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
    assign oob_c_o = |full_addr[FULL_W-1:AddrWidth];
`else
    logic unused_hi;
    assign unused_hi = ^full_addr[FULL_W-1:AddrWidth];
`endif

endmodule

// File: rtl/matrix_tile_reader.sv
// Reads one 4x4 signed tile from a byte-wide 1-cycle-latency memory into matrix_o.
// MATRIX_TILE_READER_OOB_CHECK_EN enables oob_o.
module matrix_tile_reader
    import matrix_tile_reader_pkg::*;
#(
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    matrix_tile_reader_if.slave  bus
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     k_q, k_d;
    logic [AddrWidth-1:0] base_q, base_d;
    tile_req_t            req_q, req_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cap_vld_q, cap_vld_d;
    logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
    tile_t                matrix_q, matrix_d;
    logic                 oob_q, oob_d;

    logic [AddrWidth-1:0] gen_base;
    tile_req_t            gen_req;
    logic [AddrWidth-1:0] gen_addr;
    logic                 gen_oob;

    // In IDLE the generator sees the live inputs so element 0 leaves on the accepting edge.
    assign gen_base = (state_q == IDLE) ? bus.base_addr_i : base_q;
    assign gen_req  = (state_q == IDLE) ? '{cols: bus.matrix_cols_i,
                                            row:  bus.start_row_i,
                                            col:  bus.start_col_i} : req_q;

    tile_addr_gen #(
        .AddrWidth (AddrWidth)
    ) u_addr_gen (
        .base_i   (gen_base),
        .req_i    (gen_req),
        .idx_i    (k_q[IDX_W-1:0]),
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
        .oob_c_o  (gen_oob),
`endif
        .addr_c_o (gen_addr)
    );

`ifndef MATRIX_TILE_READER_OOB_CHECK_EN
    assign gen_oob = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            k_q        <= '0;
            base_q     <= '0;
            req_q      <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            matrix_q   <= '0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            base_q     <= base_d;
            req_q      <= req_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cap_vld_q  <= cap_vld_d;
            cap_idx_q  <= cap_idx_d;
            matrix_q   <= matrix_d;
            oob_q      <= oob_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        base_d     = base_q;
        req_d      = req_q;
        mem_addr_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cap_vld_d  = 1'b0;
        cap_idx_d  = cap_idx_q;
        matrix_d   = matrix_q;
        oob_d      = oob_q;

        // Read data arrives one cycle after its address was on mem_addr_o.
        if (cap_vld_q) begin
            matrix_d[cap_idx_q[IDX_W-1:2]][cap_idx_q[1:0]] = bus.mem_rd_data_i;
        end

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    base_d     = bus.base_addr_i;
                    req_d      = gen_req;
                    mem_addr_d = gen_addr;
                    oob_d      = gen_oob;
                    k_d        = CNT_W'(1);
                    busy_d     = 1'b1;
                    state_d    = READ;
                end
            end
            READ: begin
                busy_d    = 1'b1;
                cap_vld_d = 1'b1;
                cap_idx_d = IDX_W'(k_q - CNT_W'(1));
                if (k_q == CNT_W'(NUM_ELEMS)) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    mem_addr_d = gen_addr;
                    oob_d      = oob_q | gen_oob;
                    k_d        = k_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.matrix_o   = matrix_q;
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
    assign bus.oob_o      = oob_q;
`else
    logic unused_oob;
    assign unused_oob = oob_q;
`endif

endmodule

// File: tb/tb_matrix_tile_reader.sv
// Self-checking bench for matrix_tile_reader against a behavioural tile model.
// Honours MATRIX_TILE_READER_OOB_CHECK_EN.
module tb_matrix_tile_reader;
    import matrix_tile_reader_pkg::*;

    localparam int unsigned AW = 8;
    localparam int DONE_EDGE = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_tile_reader_if #(.AddrWidth(AW)) bus ();

    matrix_tile_reader #(.AddrWidth(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    always @(posedge clk) bus.mem_rd_data_i <= mem[bus.mem_addr_o];

    int n_pass = 0;
    int n_total = 0;

    function automatic longint elem_addr(input longint base, cols, row, col, input int k);
        return base + (row + k / 4) * cols + col + k % 4;
    endfunction

    function automatic tile_t model_tile(input longint base, cols, row, col);
        tile_t t;
        for (int k = 0; k < 16; k++) t[k/4][k%4] = mem[int'(elem_addr(base, cols, row, col, k) % 256)];
        return t;
    endfunction

    function automatic logic model_oob(input longint base, cols, row, col);
        logic o = 1'b0;
        for (int k = 0; k < 16; k++) if (elem_addr(base, cols, row, col, k) >= 256) o = 1'b1;
        return o;
    endfunction

    function automatic logic get_oob();
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
        return bus.oob_o;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one transaction and reports what was observed; the callers compare.
    task automatic run_txn(input logic [7:0] base, input logic [15:0] cols, row, col,
                           output tile_t got, output int done_at, output int done_cnt,
                           output logic oob_got, output logic busy_first,
                           output logic [7:0] addr_first);
        @(negedge clk);
        bus.base_addr_i   = base;
        bus.matrix_cols_i = cols;
        bus.start_row_i   = row;
        bus.start_col_i   = col;
        bus.start_i       = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        busy_first  = bus.busy_o;
        addr_first  = bus.mem_addr_o;
        done_at = -1; done_cnt = 0; got = '0; oob_got = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    got     = bus.matrix_o;
                    oob_got = get_oob();
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy_o); else n_pass++;
        n_total++; if (bus.done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done_o); else n_pass++;
        n_total++; if (bus.mem_addr_o !== 8'h00) $display("FAIL reset_addr got=%h exp=00", bus.mem_addr_o); else n_pass++;
        n_total++; if (bus.matrix_o !== tile_t'('0)) $display("FAIL reset_matrix got=%h exp=0", bus.matrix_o); else n_pass++;
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
        n_total++; if (bus.oob_o !== 1'b0) $display("FAIL reset_oob got=%b exp=0", bus.oob_o); else n_pass++;
`endif
    endtask

    task automatic test_directed();
        logic [15:0] cases [4][3] = '{'{16'd16, 16'd0, 16'd0}, '{16'd16, 16'd3, 16'd3},
                                      '{16'd8, 16'd0, 16'd0}, '{16'd8, 16'd1, 16'd0}};
        int corners [4][2] = '{'{0, 51}, '{51, 102}, '{0, 27}, '{8, 35}};
        tile_t got, exp; int done_at, done_cnt; logic oob, busy_first; logic [7:0] a0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        for (int c = 0; c < 4; c++) begin
            exp = model_tile(0, cases[c][0], cases[c][1], cases[c][2]);
            run_txn(8'h00, cases[c][0], cases[c][1], cases[c][2], got, done_at, done_cnt, oob, busy_first, a0);
            n_total++; if (got !== exp) $display("FAIL dir%0d_tile got=%h exp=%h", c, got, exp); else n_pass++;
            n_total++; if (int'(8'(got[0][0])) !== corners[c][0]) $display("FAIL dir%0d_first got=%0d exp=%0d", c, got[0][0], corners[c][0]); else n_pass++;
            n_total++; if (int'(8'(got[3][3])) !== corners[c][1]) $display("FAIL dir%0d_last got=%0d exp=%0d", c, got[3][3], corners[c][1]); else n_pass++;
            n_total++; if (done_at !== DONE_EDGE) $display("FAIL dir%0d_done_edge got=%0d exp=%0d", c, done_at, DONE_EDGE); else n_pass++;
            n_total++; if (done_cnt !== 1) $display("FAIL dir%0d_done_count got=%0d exp=1", c, done_cnt); else n_pass++;
            n_total++; if (busy_first !== 1'b1) $display("FAIL dir%0d_busy got=%b exp=1", c, busy_first); else n_pass++;
            n_total++; if (a0 !== 8'(elem_addr(0, cases[c][0], cases[c][1], cases[c][2], 0)))
                $display("FAIL dir%0d_addr0 got=%h exp=%h", c, a0, 8'(elem_addr(0, cases[c][0], cases[c][1], cases[c][2], 0))); else n_pass++;
        end
        n_total++; if (bus.mem_addr_o !== 8'h00) $display("FAIL idle_addr got=%h exp=00", bus.mem_addr_o); else n_pass++;
    endtask

    task automatic test_wrap();
        tile_t got, exp; int done_at, done_cnt; logic oob, busy_first; logic [7:0] a0;
        exp = model_tile(8'hF0, 16, 3, 0);
        run_txn(8'hF0, 16'd16, 16'd3, 16'd0, got, done_at, done_cnt, oob, busy_first, a0);
        n_total++; if (a0 !== 8'h20) $display("FAIL wrap_addr0 got=%h exp=20", a0); else n_pass++;
        n_total++; if (got !== exp) $display("FAIL wrap_tile got=%h exp=%h", got, exp); else n_pass++;
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
        n_total++; if (oob !== 1'b1) $display("FAIL wrap_oob got=%b exp=1", oob); else n_pass++;
        n_total++; if (bus.oob_o !== 1'b1) $display("FAIL wrap_oob_hold got=%b exp=1", bus.oob_o); else n_pass++;
`endif
        run_txn(8'h00, 16'd16, 16'd0, 16'd0, got, done_at, done_cnt, oob, busy_first, a0);
        n_total++; if (got !== model_tile(0, 16, 0, 0)) $display("FAIL inrange_tile got=%h", got); else n_pass++;
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
        n_total++; if (oob !== 1'b0) $display("FAIL inrange_oob got=%b exp=0", oob); else n_pass++;
`endif
    endtask

    task automatic test_hold_start();
        logic [7:0] base = 8'($urandom); logic [15:0] cols = 16'($urandom_range(0, 20));
        logic [15:0] row = 16'($urandom_range(0, 10)); logic [15:0] col = 16'($urandom_range(0, 10));
        tile_t exp, got = '0; int done_cnt = 0, busy_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        exp = model_tile(base, cols, row, col);
        @(negedge clk);
        bus.base_addr_i = base; bus.matrix_cols_i = cols; bus.start_row_i = row; bus.start_col_i = col;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            bus.base_addr_i = 8'($urandom); bus.matrix_cols_i = 16'($urandom);
            bus.start_row_i = 16'($urandom); bus.start_col_i = 16'($urandom);
            if (i >= 10) bus.start_i = 1'b0;
            @(posedge clk); #1;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin done_cnt++; got = bus.matrix_o; end
        end
        n_total++; if (done_cnt !== 1) $display("FAIL hold_done_count got=%0d exp=1", done_cnt); else n_pass++;
        n_total++; if (got !== exp) $display("FAIL hold_tile got=%h exp=%h", got, exp); else n_pass++;
        n_total++; if (busy_cnt !== 16) $display("FAIL hold_busy_cycles got=%0d exp=16", busy_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        @(negedge clk);
        bus.base_addr_i = 8'h00; bus.matrix_cols_i = 16'd16; bus.start_row_i = 16'd1; bus.start_col_i = 16'd1;
        bus.start_i = 1'b1;
        @(posedge clk); #1; bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy_o); else n_pass++;
        n_total++; if (bus.done_o !== 1'b0) $display("FAIL abort_done got=%b exp=0", bus.done_o); else n_pass++;
        n_total++; if (bus.matrix_o !== tile_t'('0)) $display("FAIL abort_matrix got=%h exp=0", bus.matrix_o); else n_pass++;
        n_total++; if (bus.mem_addr_o !== 8'h00) $display("FAIL abort_addr got=%h exp=00", bus.mem_addr_o); else n_pass++;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (bus.done_o) done_cnt++; end
        n_total++; if (done_cnt !== 0) $display("FAIL abort_no_done got=%0d exp=0", done_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        tile_t exp_b, got; int done_at, done_cnt, seen = 0; logic oob, busy_first; logic [7:0] a0;
        logic [7:0] base_b = 8'($urandom); logic [15:0] cols_b = 16'($urandom_range(0, 30));
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        exp_b = model_tile(base_b, cols_b, 2, 5);
        @(negedge clk);
        bus.base_addr_i = 8'h10; bus.matrix_cols_i = 16'd7; bus.start_row_i = 16'd0; bus.start_col_i = 16'd2;
        bus.start_i = 1'b1;
        @(posedge clk); #1; bus.start_i = 1'b0;
        for (int i = 1; i <= 30 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) seen = i;
        end
        n_total++; if (seen !== DONE_EDGE) $display("FAIL b2b_first_done got=%0d exp=%0d", seen, DONE_EDGE); else n_pass++;
        n_total++; if (bus.matrix_o !== model_tile(8'h10, 7, 0, 2)) $display("FAIL b2b_first_tile got=%h", bus.matrix_o); else n_pass++;
        bus.base_addr_i = base_b; bus.matrix_cols_i = cols_b; bus.start_row_i = 16'd2; bus.start_col_i = 16'd5;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL b2b_start_in_done got=%b exp=0", bus.busy_o); else n_pass++;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        n_total++; if (bus.busy_o !== 1'b1) $display("FAIL b2b_start_in_idle got=%b exp=1", bus.busy_o); else n_pass++;
        done_at = -1; done_cnt = 0; got = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) begin done_cnt++; if (done_at < 0) begin done_at = i; got = bus.matrix_o; end end
        end
        n_total++; if (done_at !== DONE_EDGE) $display("FAIL b2b_second_done got=%0d exp=%0d", done_at, DONE_EDGE); else n_pass++;
        n_total++; if (got !== exp_b) $display("FAIL b2b_second_tile got=%h exp=%h", got, exp_b); else n_pass++;
        oob = 1'b0; busy_first = 1'b0; a0 = 8'h00;
    endtask

    task automatic test_random();
        tile_t got, exp; int done_at, done_cnt; logic oob, exp_oob, busy_first; logic [7:0] a0;
        logic [7:0] base; logic [15:0] cols, row, col;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            base = 8'($urandom);
            cols = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 64));
            row  = 16'($urandom_range(0, 40));
            col  = 16'($urandom_range(0, 60));
            if (t == 5) begin base = 8'h00; cols = 16'd0; row = 16'd0; col = 16'd0; end
            exp     = model_tile(base, cols, row, col);
            exp_oob = model_oob(base, cols, row, col);
            run_txn(base, cols, row, col, got, done_at, done_cnt, oob, busy_first, a0);
            n_total++; if (got !== exp) $display("FAIL rnd%0d_tile got=%h exp=%h", t, got, exp); else n_pass++;
            n_total++; if (done_at !== DONE_EDGE || done_cnt !== 1)
                $display("FAIL rnd%0d_done got_edge=%0d got_cnt=%0d exp_edge=%0d exp_cnt=1", t, done_at, done_cnt, DONE_EDGE); else n_pass++;
`ifdef MATRIX_TILE_READER_OOB_CHECK_EN
            n_total++; if (oob !== exp_oob) $display("FAIL rnd%0d_oob got=%b exp=%b", t, oob, exp_oob); else n_pass++;
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0; bus.base_addr_i = '0; bus.matrix_cols_i = '0;
        bus.start_row_i = '0; bus.start_col_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        test_reset();
        test_directed();
        test_wrap();
        test_hold_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
